present_cbc_ctrl: RTL and testbench
===================================

# present_cbc_ctrl

Cipher-block-chaining front end for the PRESENT-80 round engine: accepts a stream of 64-bit plaintext blocks on a valid/ready interface, XORs each with the chaining value (IV or previous ciphertext), and drives the `encrypt_v2` req/ack handshake. It captures each ciphertext, returns it on a valid/ready output, and uses it as the next chaining value. It sits directly upstream of `encrypt_v2`, between the host stream and the round engine.

## Interface
- No parameters; widths are fixed by PRESENT-80: 64-bit block, 80-bit key.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- iv_load  in  1  pulse: latch `iv` and `key`, clear `err`; honoured only in IDLE.
- iv  in  64  initialisation vector.
- key  in  80  encryption key.
- in_valid / in_ready  in/out  1  plaintext handshake.
- in_data  in  64  plaintext block.
- in_last  in  1  marks final block of a message.
- out_valid / out_ready  out/in  1  ciphertext handshake.
- out_data  out  64  ciphertext block.
- out_last  out  1  copy of the accepted block's `in_last`.
- enc_req  out  1  to `encrypt_v2.req`.
- enc_K  out  80  to `encrypt_v2.K`; the latched key.
- enc_M  out  64  to `encrypt_v2.M`; registered `in_data ^ chain`.
- enc_ack  in  1  from `encrypt_v2.ack`.
- enc_C  in  64  from `encrypt_v2.C`.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog timeout flag.

## Operation
- States: IDLE, REQ, DROP, OUT.
- IDLE:
  - `in_ready = !iv_load`.
  - `iv_load` latches `iv` into both `chain` and `iv_r`, latches `key` into `key_r`, clears `err`, and has priority over `in_valid` in the same cycle.
  - On `in_valid && in_ready`: `enc_M <= in_data ^ chain`, `last_r <= in_last`, clear watchdog, go to REQ.
- REQ:
  - `enc_req = 1`; the 6-bit watchdog increments each cycle.
  - On the first edge at which `enc_ack` is sampled high: `out_data <= enc_C`, go to DROP.
  - If the watchdog reaches 63 with no ack: set `err`, `out_data <= 0`, go to DROP. Chaining still proceeds with the 0 value.
- DROP:
  - `enc_req = 0` for exactly one cycle so the engine sees a falling req and clears ack.
  - `chain <= out_data`, or `iv_r` if `last_r` is set, so the next message restarts from the IV.
  - Go to OUT.
- OUT:
  - `out_valid = 1`, `out_last = last_r`; `out_data` held stable until `out_ready`.
  - On handshake, go to IDLE.
- `enc_K = key_r` at all times. `enc_req` is registered and glitch-free.
- Reset values: state IDLE; `chain`, `iv_r`, `key_r`, `enc_M`, `out_data` = 0; `enc_req`, `out_valid`, `out_last`, `err`, `busy` = 0; `in_ready = 1` (combinational in IDLE).
- Reset mid-operation returns to IDLE at once and drops `enc_req`. The engine has no reset and clears its ack on the req fall. The block in flight is discarded.

## Timing
- Accept at edge A. `enc_req` is high from A+1.
- Ack sampled at edge B. `enc_req` is low from B+1. `out_valid` is high from B+2.
- Minimum spacing between successive `enc_req` rising edges = engine latency + 3 cycles, assuming `out_ready` is held high.
- At most one block is in flight; `in_ready = 0` throughout REQ, DROP and OUT.
- `enc_ack` seen in any state other than REQ is ignored.
- `iv_load` outside IDLE is ignored; there is no queued load.

## Configuration
- `PRESENT_CBC_BYPASS_EN`
  - Defined: adds input `cbc_bypass`, sampled at `in_valid && in_ready`. When it is set, `enc_M = in_data` (ECB) and `chain` is not updated in DROP for that block.
  - Undefined: the port is absent and every block is chained.

## Test plan
- Reset, then `iv_load` with iv=0 and key=0, then send in_data=0 with in_last=0 -> out_data=5579C1387B228445 and out_last=0.
- Continue with in_data=5579C1387B228445 and in_last=1 -> enc_M=0, out_data=5579C1387B228445, out_last=1. The next block then chains from IV 0.
- key=FFFFFFFFFFFFFFFFFFFF, iv=0, in_data=0 -> out_data=E72C46C0F5945049. Also check `enc_req` is low for exactly one cycle after ack, and `in_ready` is 0 while busy.
- Hold `out_ready=0` for 10 cycles -> `out_data` is stable and `out_valid` stays 1. No second `enc_req` is issued.
- Tie `enc_ack=0` -> `err=1` after 63 cycles in REQ, out_data=0. A following `iv_load` clears `err`.
- Assert `rst_n=0` for one cycle mid-REQ -> `enc_req=0` and `out_valid=0` next cycle, state IDLE, `chain=0`. A following block with iv=0 and key=0 still yields 5579C1387B228445.

Source files
------------

// File: rtl/present_cbc_ctrl.sv
// present_cbc_ctrl: CBC chaining front end driving the PRESENT-80 encrypt_v2 req/ack engine.
// Optional per-block ECB bypass when PRESENT_CBC_BYPASS_EN is defined (adds cbc_bypass input).
module present_cbc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iv_load,
  input  logic [63:0] iv,
  input  logic [79:0] key,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
`ifdef PRESENT_CBC_BYPASS_EN
  input  logic        cbc_bypass,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        enc_req,
  output logic [79:0] enc_K,
  output logic [63:0] enc_M,
  input  logic        enc_ack,
  input  logic [63:0] enc_C,
  output logic        busy,
  output logic        err
);

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned KEY_W  = 80;
  localparam int unsigned WDOG_W = 6;
  // Last watchdog value seen in REQ before the timeout edge (63 REQ cycles total).
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(62);

  typedef enum logic [1:0] {IDLE, REQ, DROP, OUT} state_t;

  state_t            state;
  state_t            next_state;
  logic [BLK_W-1:0]  chain;
  logic [BLK_W-1:0]  iv_r;
  logic [KEY_W-1:0]  key_r;
  logic              last_r;
  logic [WDOG_W-1:0] wdog;
  logic              timeout_c;
`ifdef PRESENT_CBC_BYPASS_EN
  logic              byp_r;
`endif

  assign in_ready  = (state == IDLE) && !iv_load;
  assign enc_K     = key_r;
  assign timeout_c = !enc_ack && (wdog == WDOG_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!iv_load && in_valid)    next_state = REQ;
      REQ:  if (enc_ack || timeout_c)    next_state = DROP;
      DROP:                              next_state = OUT;
      OUT:  if (out_ready)               next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_req   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      enc_req   <= (next_state == REQ);
      out_valid <= (next_state == OUT);
      out_last  <= (next_state == OUT) ? last_r : 1'b0;
      busy      <= (next_state != IDLE);
    end
  end

  // Datapath: key/IV latch, whitening, ciphertext capture, chaining, watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain    <= '0;
      iv_r     <= '0;
      key_r    <= '0;
      enc_M    <= '0;
      out_data <= '0;
      last_r   <= 1'b0;
      wdog     <= '0;
      err      <= 1'b0;
`ifdef PRESENT_CBC_BYPASS_EN
      byp_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iv_load) begin
            chain <= iv;
            iv_r  <= iv;
            key_r <= key;
            err   <= 1'b0;
          end else if (in_valid) begin
`ifdef PRESENT_CBC_BYPASS_EN
            enc_M <= cbc_bypass ? in_data : (in_data ^ chain);
            byp_r <= cbc_bypass;
`else
            enc_M <= in_data ^ chain;
`endif
            last_r <= in_last;
            wdog   <= '0;
          end
        end
        REQ: begin
          wdog <= wdog + WDOG_W'(1);
          if (enc_ack) begin
            out_data <= enc_C;
          end else if (timeout_c) begin
            err      <= 1'b1;
            out_data <= '0;
          end
        end
        DROP: begin
          // A final block restarts the next message from the IV.
`ifdef PRESENT_CBC_BYPASS_EN
          if (!byp_r) chain <= last_r ? iv_r : out_data;
`else
          chain <= last_r ? iv_r : out_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_cbc_ctrl.sv
// Scoreboard bench for present_cbc_ctrl with a known-answer PRESENT-80 engine model.
module tb_present_cbc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv_load;
  logic [63:0] iv;
  logic [79:0] key;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        enc_req;
  logic [79:0] enc_K;
  logic [63:0] enc_M;
  logic        enc_ack = 1'b0;
  logic [63:0] enc_C   = 64'h0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  present_cbc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .enc_req(enc_req), .enc_K(enc_K), .enc_M(enc_M), .enc_ack(enc_ack), .enc_C(enc_C),
    .busy(busy), .err(err)
  );

  localparam logic [63:0] C_K0_P0 = 64'h5579C1387B228445;
  localparam logic [63:0] C_KF_P0 = 64'hE72C46C0F5945049;
  localparam logic [63:0] C_K0_PF = 64'hA112FFC72F68417B;
  localparam logic [63:0] C_KF_PF = 64'h3333DCD3213210D2;
  localparam int ENG_LAT = 3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Published PRESENT-80 known answers; anything else returns a marker value.
  function automatic logic [63:0] present_ref(input logic [79:0] k, input logic [63:0] m);
    if (k == 80'h0 && m == 64'h0) return C_K0_P0;
    if (k == {80{1'b1}} && m == 64'h0) return C_KF_P0;
    if (k == 80'h0 && m == {64{1'b1}}) return C_K0_PF;
    if (k == {80{1'b1}} && m == {64{1'b1}}) return C_KF_PF;
    return 64'hBAD0BAD0BAD0BAD0;
  endfunction

  // Engine model: ack after ENG_LAT cycles of req, held until req falls.
  logic ack_en = 1'b1;
  int   eng_cnt = 0;
  always @(posedge clk) begin
    if (!enc_req) begin
      enc_ack <= 1'b0;
      eng_cnt <= 0;
    end else if (!enc_ack) begin
      if (eng_cnt >= ENG_LAT - 1 && ack_en) begin
        enc_ack <= 1'b1;
        enc_C   <= present_ref(enc_K, enc_M);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // Monitor: compare each output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 80'(out_data), 80'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 80'(out_data), 80'(e.data));
        chk("out_last", 80'(out_last), 80'(e.last));
        chk("out_err",  80'(err),      80'(e.err));
      end
    end
  end

  task automatic load(input logic [63:0] v, input logic [79:0] k);
    @(posedge clk); #1;
    iv = v; key = k; iv_load = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("ready_during_load", 80'(in_ready), 80'h0);
    @(posedge clk); #1;
    iv_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 80'(in_ready), 80'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 80'(q.size()), 80'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; iv_load = 1'b0; iv = '0; key = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  80'(in_ready),  80'h1);
    chk("rst_enc_req",   80'(enc_req),   80'h0);
    chk("rst_out_valid", 80'(out_valid), 80'h0);
    chk("rst_busy",      80'(busy),      80'h0);
    chk("rst_err",       80'(err),       80'h0);
    chk("rst_out_data",  80'(out_data),  80'h0);
    chk("rst_enc_M",     80'(enc_M),     80'h0);
    chk("rst_enc_K",     enc_K,          80'h0);

    // Basic chaining with key 0, IV 0.
    load(64'h0, 80'h0);
    q.push_back('{C_K0_P0, 1'b0, 1'b0});
    send(64'h0, 1'b0);
    drain();

    q.push_back('{C_K0_P0, 1'b1, 1'b0});
    send(C_K0_P0, 1'b1);
    @(negedge clk);
    chk("chained_enc_M", 80'(enc_M),    80'h0);
    chk("busy_in_req",   80'(busy),     80'h1);
    chk("ready_in_req",  80'(in_ready), 80'h0);
    drain();

    q.push_back('{C_K0_P0, 1'b0, 1'b0});
    send(64'h0, 1'b0);
    drain();

    // Nonzero IV: last block must restart from the IV.
    load({64{1'b1}}, 80'h0);
    q.push_back('{C_K0_PF, 1'b1, 1'b0});
    send(64'h0, 1'b1);
    drain();
    q.push_back('{C_K0_PF, 1'b0, 1'b0});
    send(64'h0, 1'b0);
    drain();

    // All-ones key, with req/ack timing checks.
    load(64'h0, {80{1'b1}});
    chk("enc_K_latched", enc_K, {80{1'b1}});
    q.push_back('{C_KF_P0, 1'b0, 1'b0});
    send(64'h0, 1'b0);
    n = 0;
    @(negedge clk);
    chk("req_rise", 80'(enc_req), 80'h1);
    while (!enc_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", 80'(enc_ack), 80'h1);
    @(negedge clk);
    chk("drop_req",   80'(enc_req),   80'h0);
    chk("drop_valid", 80'(out_valid), 80'h0);
    chk("drop_busy",  80'(busy),      80'h1);
    chk("drop_ready", 80'(in_ready),  80'h0);
    @(negedge clk);
    chk("out_valid_b2", 80'(out_valid), 80'h1);
    chk("out_req_b2",   80'(enc_req),   80'h0);
    drain();

    // Back-pressure: output held stable, no new request.
    @(posedge clk); #1 out_ready = 1'b0;
    q.push_back('{C_KF_P0, 1'b1, 1'b0});
    send(C_KF_P0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 80'(out_valid), 80'h1);
      chk("stall_data",  80'(out_data),  80'(C_KF_P0));
      chk("stall_req",   80'(enc_req),   80'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Watchdog timeout.
    ack_en = 1'b0;
    q.push_back('{64'h0, 1'b0, 1'b1});
    send(64'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 200 && !out_valid; i++) begin
      @(negedge clk);
      if (enc_req) n++;
    end
    chk("wdog_req_cycles", 80'(n),   80'd63);
    chk("wdog_err",        80'(err), 80'h1);
    ack_en = 1'b1;
    drain();
    load(64'h0, 80'h0);
    @(negedge clk);
    chk("err_cleared", 80'(err), 80'h0);

    // Reset mid-request discards the block.
    ack_en = 1'b0;
    send(64'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req",   80'(enc_req),   80'h0);
    chk("midrst_valid", 80'(out_valid), 80'h0);
    chk("midrst_busy",  80'(busy),      80'h0);
    chk("midrst_ready", 80'(in_ready),  80'h1);
    ack_en = 1'b1;
    q.push_back('{C_K0_P0, 1'b0, 1'b0});
    send(64'h0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
